// File: rtl/score_keeper.sv
// score_keeper: two-player hit scoring with combo bonus, BCD scores and a BCD countdown.
// Hits are rising edges of the judge's sticky hit levels; a clear marker on an armed mole is a miss.
module score_keeper #(
    parameter int GAME_SEC = 60,
    parameter int COMBO_TH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sec_tick,
    input  logic       hit_0,
    input  logic       hit_1,
    input  logic [3:0] pos_0,
    input  logic [3:0] pos_1,
    output logic       playing,
    output logic       game_over,
    output logic [7:0] score_0,
    output logic [7:0] score_1,
    output logic [7:0] time_left,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    localparam logic [7:0] GAME_BCD = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};
    state_t state, state_n;
    logic [1:0][7:0] score, score_n;
    logic [1:0][2:0] streak, streak_n;
    logic [1:0][3:0] pos_v;
    logic [1:0] armed, armed_n, hit_prev, hit_v, hit_ev;
    logic [7:0] time_n;
    logic [1:0] winner_n;
    logic go, act;

    function automatic logic [7:0] bcd_add(input logic [7:0] s, input logic [1:0] n);
        logic [6:0] b;
        b = 7'(s[7:4]) * 7'd10 + 7'(s[3:0]) + 7'(n);
        if (b > 7'd99)
            b = 7'd99;
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

    assign hit_v = {hit_1, hit_0};
    assign pos_v = {pos_1, pos_0};
    assign hit_ev = hit_v & ~hit_prev;
    assign go = start && state != PLAY;
    assign act = state == PLAY;
    assign playing = act;
    assign game_over = state == OVER;
    assign score_0 = score[0];
    assign score_1 = score[1];

    always_comb begin
        state_n = state;
        score_n = score;
        streak_n = streak;
        armed_n = armed;
        time_n = time_left;
        winner_n = winner;
        if (go) begin
            state_n = PLAY;
            score_n = '0;
            streak_n = '0;
            armed_n = '0;
            time_n = GAME_BCD;
            winner_n = 2'b00;
        end else if (act) begin
            for (int p = 0; p < 2; p++) begin
                if (hit_ev[p]) begin
                    score_n[p] = bcd_add(score[p], (32'(streak[p]) < COMBO_TH) ? 2'd1 : 2'd2);
                    streak_n[p] = (streak[p] == 3'd7) ? streak[p] : streak[p] + 3'd1;
                end else if (pos_v[p] == 4'd11 && armed[p]) begin
                    streak_n[p] = 3'd0;
                end
                armed_n[p] = (hit_ev[p] || pos_v[p] == 4'd11) ? 1'b0 : (pos_v[p] != 4'd0) ? 1'b1 : armed[p];
            end
            if (sec_tick && time_left != 8'h00) begin
                time_n = (time_left[3:0] == 4'd0) ? {time_left[7:4] - 4'd1, 4'd9}
                                                 : {time_left[7:4], time_left[3:0] - 4'd1};
                // Winner uses post-update scores so final-second hits count.
                if (time_left == 8'h01) begin
                    state_n = OVER;
                    winner_n = (score_n[0] > score_n[1]) ? 2'b01 : (score_n[1] > score_n[0]) ? 2'b10 : 2'b11;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            score <= '0;
            streak <= '0;
            armed <= '0;
            hit_prev <= '0;
            time_left <= '0;
            winner <= '0;
        end else begin
            state <= state_n;
            score <= score_n;
            streak <= streak_n;
            armed <= armed_n;
            hit_prev <= hit_v;
            time_left <= time_n;
            winner <= winner_n;
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table vectors, directed corner sequences and random play against an integer model.
module tb_score_keeper;
    logic clk, rst, start, sec_tick, hit_0, hit_1;
    logic [3:0] pos_0, pos_1;
    logic pl_a, ov_a, pl_b, ov_b;
    logic [7:0] s0_a, s1_a, tl_a, s0_b, s1_b, tl_b;
    logic [1:0] w_a, w_b;
    int n_chk = 0, n_fail = 0;

    score_keeper #(.GAME_SEC(12), .COMBO_TH(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .hit_0(hit_0), .hit_1(hit_1),
        .pos_0(pos_0), .pos_1(pos_1), .playing(pl_a), .game_over(ov_a), .score_0(s0_a),
        .score_1(s1_a), .time_left(tl_a), .winner(w_a));

    score_keeper #(.GAME_SEC(2), .COMBO_TH(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .hit_0(hit_0), .hit_1(hit_1),
        .pos_0(pos_0), .pos_1(pos_1), .playing(pl_b), .game_over(ov_b), .score_0(s0_b),
        .score_1(s1_b), .time_left(tl_b), .winner(w_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: scores/time as plain integers; state 0 idle, 1 play, 2 over; winner 1/2/3.
    int gs[2];
    int m_st[2], m_tl[2], m_win[2], m_hp[2];
    int m_sc[2][2], m_stk[2][2], m_arm[2][2];

    typedef struct {
        int st, tk, h0, h1, p0, p1, s0, s1, tl, pl, ov, w;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_tl[d] = 0; m_win[d] = 0;
            for (int p = 0; p < 2; p++) begin
                m_sc[d][p] = 0; m_stk[d][p] = 0; m_arm[d][p] = 0; m_hp[p] = 0;
            end
        end
    endtask

    task automatic model_step();
        int hv[2], pv[2];
        bit ev;
        hv[0] = int'(hit_0); hv[1] = int'(hit_1);
        pv[0] = int'(pos_0); pv[1] = int'(pos_1);
        for (int d = 0; d < 2; d++) begin
            if (m_st[d] != 1 && start) begin
                m_st[d] = 1; m_tl[d] = gs[d]; m_win[d] = 0;
                for (int p = 0; p < 2; p++) begin
                    m_sc[d][p] = 0; m_stk[d][p] = 0; m_arm[d][p] = 0;
                end
            end else if (m_st[d] == 1) begin
                for (int p = 0; p < 2; p++) begin
                    ev = hv[p] == 1 && m_hp[p] == 0;
                    if (ev) begin
                        m_sc[d][p] += (m_stk[d][p] < 3) ? 1 : 2;
                        if (m_sc[d][p] > 99) m_sc[d][p] = 99;
                        if (m_stk[d][p] < 7) m_stk[d][p]++;
                    end else if (pv[p] == 11 && m_arm[d][p] == 1) begin
                        m_stk[d][p] = 0;
                    end
                    if (ev || pv[p] == 11) m_arm[d][p] = 0;
                    else if (pv[p] != 0) m_arm[d][p] = 1;
                end
                if (sec_tick && m_tl[d] > 0) begin
                    m_tl[d]--;
                    if (m_tl[d] == 0) begin
                        m_st[d] = 2;
                        m_win[d] = (m_sc[d][0] > m_sc[d][1]) ? 1 : (m_sc[d][1] > m_sc[d][0]) ? 2 : 3;
                    end
                end
            end
        end
        m_hp = hv;
    endtask

    task automatic compare_dut(input int d, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] tl,
                               input logic pl, input logic ov, input logic [1:0] w);
        check($sformatf("dut%0d.score_0", d), s0, bcd(m_sc[d][0]));
        check($sformatf("dut%0d.score_1", d), s1, bcd(m_sc[d][1]));
        check($sformatf("dut%0d.time_left", d), tl, bcd(m_tl[d]));
        check($sformatf("dut%0d.playing", d), {7'd0, pl}, {7'd0, m_st[d] == 1});
        check($sformatf("dut%0d.game_over", d), {7'd0, ov}, {7'd0, m_st[d] == 2});
        check($sformatf("dut%0d.winner", d), {6'd0, w}, 8'(m_win[d]));
    endtask

    task automatic compare_all();
        compare_dut(0, s0_a, s1_a, tl_a, pl_a, ov_a, w_a);
        compare_dut(1, s0_b, s1_b, tl_b, pl_b, ov_b, w_b);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asserted just after an edge: outputs must clear before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        check("rst.playing", {7'd0, pl_a}, 8'h00);
        check("rst.game_over", {7'd0, ov_a}, 8'h00);
        check("rst.score_0", s0_a, 8'h00);
        check("rst.score_1", s1_a, 8'h00);
        check("rst.time_left", tl_a, 8'h00);
        check("rst.winner", {6'd0, w_a}, 8'h00);
        compare_all();
        rst = 1'b0;
    endtask

    task automatic add_vec(input int st, tk, h0, h1, p0, p1, s0, s1, tl, pl, ov, w);
        vec_t v;
        v = '{st, tk, h0, h1, p0, p1, s0, s1, tl, pl, ov, w};
        tbl.push_back(v);
    endtask

    task automatic pulse(input bit p0, input bit p1);
        hit_0 = p0; hit_1 = p1;
        step();
        hit_0 = 1'b0; hit_1 = 1'b0;
        step();
    endtask

    initial begin
        gs[0] = 12; gs[1] = 2;
        rst = 1'b0; start = 1'b0; sec_tick = 1'b0; hit_0 = 1'b0; hit_1 = 1'b0;
        pos_0 = 4'd0; pos_1 = 4'd0;
        #1;
        do_reset();

        // st tk h0 h1 p0 p1 s0 s1 tl pl ov w   (dut_a, GAME_SEC 12)
        add_vec(1, 0, 0, 0,  0, 0, 'h00, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0,  5, 0, 'h00, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0,  5, 0, 'h01, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0, 11, 0, 'h01, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0,  0, 0, 'h01, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0,  0, 0, 'h02, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0, 11, 0, 'h02, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0,  0, 0, 'h03, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0,  0, 0, 'h03, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0,  0, 0, 'h05, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0,  5, 0, 'h05, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0, 11, 0, 'h05, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 0, 0,  0, 0, 'h05, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 0, 1, 0,  0, 0, 'h06, 'h00, 'h12, 1, 0, 0);
        add_vec(0, 1, 0, 0,  0, 0, 'h06, 'h00, 'h11, 1, 0, 0);
        add_vec(0, 1, 0, 0,  0, 0, 'h06, 'h00, 'h10, 1, 0, 0);
        add_vec(0, 1, 0, 0,  0, 0, 'h06, 'h00, 'h09, 1, 0, 0);
        add_vec(1, 0, 0, 0,  0, 0, 'h06, 'h00, 'h09, 1, 0, 0);
        add_vec(0, 0, 1, 1,  0, 0, 'h07, 'h01, 'h09, 1, 0, 0);
        foreach (tbl[i]) begin
            start = 1'(tbl[i].st); sec_tick = 1'(tbl[i].tk);
            hit_0 = 1'(tbl[i].h0); hit_1 = 1'(tbl[i].h1);
            pos_0 = 4'(tbl[i].p0); pos_1 = 4'(tbl[i].p1);
            step();
            check($sformatf("vec%0d.score_0", i), s0_a, 8'(tbl[i].s0));
            check($sformatf("vec%0d.score_1", i), s1_a, 8'(tbl[i].s1));
            check($sformatf("vec%0d.time_left", i), tl_a, 8'(tbl[i].tl));
            check($sformatf("vec%0d.playing", i), {7'd0, pl_a}, 8'(tbl[i].pl));
            check($sformatf("vec%0d.game_over", i), {7'd0, ov_a}, 8'(tbl[i].ov));
            check($sformatf("vec%0d.winner", i), {6'd0, w_a}, 8'(tbl[i].w));
        end
        start = 1'b0; sec_tick = 1'b0; hit_0 = 1'b0; hit_1 = 1'b0; pos_0 = 4'd0; pos_1 = 4'd0;
        step();

        // Reset in the middle of a game
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        hit_0 = 1'b1;
        repeat (20) step();
        check("held_hit.score_0", s0_a, 8'h01);
        hit_0 = 1'b0;
        step();

        // Short game on dut_b ends in a tie
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        repeat (3) pulse(1'b1, 1'b1);
        sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
        sec_tick = 1'b1; step(); sec_tick = 1'b0;
        check("tie.score_0", s0_b, 8'h03);
        check("tie.score_1", s1_b, 8'h03);
        check("tie.time_left", tl_b, 8'h00);
        check("tie.game_over", {7'd0, ov_b}, 8'h01);
        check("tie.winner", {6'd0, w_b}, 8'h03);
        check("tie.a_time_left", tl_a, 8'h10);
        pulse(1'b1, 1'b0);
        check("over_hold.score_0", s0_b, 8'h03);

        // Player 1 saturation at 99
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        repeat (49) pulse(1'b0, 1'b1);
        check("sat.score_95", s1_a, 8'h95);
        pos_1 = 4'd5; step(); pos_1 = 4'd11; step(); pos_1 = 4'd0;
        repeat (3) pulse(1'b0, 1'b1);
        check("sat.score_98", s1_a, 8'h98);
        pulse(1'b0, 1'b1);
        check("sat.score_99", s1_a, 8'h99);
        pulse(1'b0, 1'b1);
        check("sat.score_hold", s1_a, 8'h99);

        // Random play
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r0, r1;
            start = ($urandom_range(0, 40) == 0);
            sec_tick = ($urandom_range(0, 7) == 0);
            hit_0 = ($urandom_range(0, 2) == 0);
            hit_1 = ($urandom_range(0, 2) == 0);
            r0 = $urandom_range(0, 3); r1 = $urandom_range(0, 3);
            pos_0 = (r0 == 0) ? 4'd0 : (r0 == 1) ? 4'd11 : 4'($urandom_range(1, 15));
            pos_1 = (r1 == 0) ? 4'd0 : (r1 == 1) ? 4'd11 : 4'($urandom_range(1, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
